// File: rtl/logic_exec_stage.sv
// logic_exec_stage: execute-stage wrapper around the 8-bit MIPS logic unit
// (AND/OR/XOR/NOR). Tokens travel SKID -> OP -> RES. OP feeds the external
// logic unit through lu_*. RES registers the result toward writeback.
//
// Optional feature macro: LOGIC_EXEC_FLAGS_EN
//   When defined, adds the out_zero and out_parity outputs. Both are
//   registered alongside RES.
//   When undefined, those ports and their logic are absent.
//
// Handshake rules (both ports):
//   - A transfer happens on a rising edge where valid & ready are both 1.
//   - A producer holding valid keeps its payload stable until that transfer.
//   - out_valid never depends combinationally on out_ready.
//   - in_ready is a register, gated combinationally only by flush.
module logic_exec_stage #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int RD_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [RD_W-1:0]  in_rd,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [SEL_W-1:0] lu_sel,
  input  logic [WIDTH-1:0] lu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic [CNT_W-1:0] op_count
`ifdef LOGIC_EXEC_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  // Skid buffer: catches a token accepted while OP is blocked.
  logic             skid_v;
  logic [WIDTH-1:0] skid_a;
  logic [WIDTH-1:0] skid_b;
  logic [SEL_W-1:0] skid_sel;
  logic [RD_W-1:0]  skid_rd;

  // Operand register: drives the logic unit directly.
  logic             op_v;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SEL_W-1:0] op_sel;
  logic [RD_W-1:0]  op_rd;

  // Result register: presented to writeback.
  logic             res_v;
  logic [WIDTH-1:0] res_result;
  logic [RD_W-1:0]  res_rd;

  logic             ready_q;
  logic [CNT_W-1:0] count_q;

  // Movement decisions for this cycle.
  logic in_fire;
  logic out_fire;
  logic res_load;
  logic op_load;
  logic op_from_skid;
  logic op_from_in;
  logic skid_push;
  logic skid_v_next;

  // Decide where every token moves this cycle.
  always_comb begin
    in_fire      = in_valid & in_ready;
    out_fire     = res_v & out_ready;
    // RES can take a new value when empty or when its token is leaving.
    res_load     = ~res_v | out_ready;
    // OP can take a new value when empty or when its token moves into RES.
    op_load      = ~op_v | res_load;
    // The skid token is older than anything at the port, so it goes first.
    op_from_skid = op_load & skid_v;
    op_from_in   = op_load & ~skid_v & in_fire;
    // An accepted token that cannot reach OP parks in the skid buffer.
    skid_push    = in_fire & ~op_load;
    if (flush) begin
      skid_v_next = 1'b0;
    end else if (skid_push) begin
      skid_v_next = 1'b1;
    end else if (op_from_skid) begin
      skid_v_next = 1'b0;
    end else begin
      skid_v_next = skid_v;
    end
  end

  // Valid bits for the three storage stages. Flush clears them all on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v <= 1'b0;
      op_v   <= 1'b0;
      res_v  <= 1'b0;
    end else if (flush) begin
      skid_v <= 1'b0;
      op_v   <= 1'b0;
      res_v  <= 1'b0;
    end else begin
      skid_v <= skid_v_next;
      if (op_load) begin
        op_v <= op_from_skid | op_from_in;
      end
      if (res_load) begin
        res_v <= op_v;
      end
    end
  end

  // Registered ready tracks skid occupancy.
  // It stays 0 in reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ~skid_v_next;
    end
  end

  // Skid payload capture. Flush leaves the data registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_a   <= '0;
      skid_b   <= '0;
      skid_sel <= '0;
      skid_rd  <= '0;
    end else if (!flush && skid_push) begin
      skid_a   <= in_a;
      skid_b   <= in_b;
      skid_sel <= in_sel;
      skid_rd  <= in_rd;
    end
  end

  // Operand payload: from skid when it holds a token, otherwise from the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= '0;
      op_rd  <= '0;
    end else if (!flush) begin
      if (op_from_skid) begin
        op_a   <= skid_a;
        op_b   <= skid_b;
        op_sel <= skid_sel;
        op_rd  <= skid_rd;
      end else if (op_from_in) begin
        op_a   <= in_a;
        op_b   <= in_b;
        op_sel <= in_sel;
        op_rd  <= in_rd;
      end
    end
  end

  // Result payload: sample the logic unit whenever RES is free to change.
  // This holds the value stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_result <= '0;
      res_rd     <= '0;
    end else if (!flush && res_load) begin
      res_result <= lu_result;
      res_rd     <= op_rd;
    end
  end

  // Completed-operation counter. It wraps naturally.
  // A handshake coinciding with flush does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (out_fire && !flush) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

`ifdef LOGIC_EXEC_FLAGS_EN
  logic zero_q;
  logic parity_q;

  // Result flags travel with RES and hold with it under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (!flush && res_load) begin
      zero_q   <= (lu_result == '0);
      parity_q <= ^lu_result;
    end
  end

  assign out_zero   = zero_q;
  assign out_parity = parity_q;
`endif

  assign in_ready   = ready_q & ~flush;
  assign lu_a       = op_a;
  assign lu_b       = op_b;
  assign lu_sel     = op_sel;
  assign out_valid  = res_v;
  assign out_result = res_result;
  assign out_rd     = res_rd;
  assign op_count   = count_q;

endmodule
